// File: rtl/rx_byte_packer.sv
// Packs 8-bit AXI4-Stream bytes into 64-bit words, tags the last word
// with packet length and error flag, and counts good/bad packets.
//
// Ports:
//   clk, resetn              core clock, synchronous active-low reset
//   s_tdata/tvalid/tlast     8-bit input stream, s_tready back-pressure
//   s_err                    bad-frame strobe, valid with s_tlast
//   m_tdata/tstrb/tvalid     64-bit output word, little-endian lanes
//   m_tlast/tuser/m_err      last flag, byte length, bad-frame flag
//   m_tready                 downstream ready
//   good_pkts/bad_pkts       delivered packet counters (wrapping)
module rx_byte_packer #(
  parameter int M_DATA_WIDTH = 64,
  parameter int LEN_WIDTH    = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [7:0]                s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  input  logic                      s_err,
  output logic [M_DATA_WIDTH-1:0]   m_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_tstrb,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  output logic [LEN_WIDTH-1:0]      m_tuser,
  output logic                      m_err,
  input  logic                      m_tready,
  output logic [CNT_WIDTH-1:0]      good_pkts,
  output logic [CNT_WIDTH-1:0]      bad_pkts
);

  localparam int NB = M_DATA_WIDTH / 8;

  logic [M_DATA_WIDTH-1:0] acc;
  logic [2:0]              idx;
  logic [LEN_WIDTH-1:0]    len;

  // Holding slot for a word completed while the output is stalled
  logic                    pend;
  logic [M_DATA_WIDTH-1:0] pend_data;
  logic [NB-1:0]           pend_strb;
  logic                    pend_last;
  logic [LEN_WIDTH-1:0]    pend_user;
  logic                    pend_err;

  logic                    accept;
  logic                    done;
  logic                    out_free;
  logic [LEN_WIDTH-1:0]    len_inc;
  logic [M_DATA_WIDTH-1:0] word;
  logic [NB-1:0]           strb;
  logic [LEN_WIDTH-1:0]    user;
  logic                    err;

  assign s_tready = resetn & ~pend;
  assign accept   = s_tvalid & s_tready;
  assign done     = accept & ((idx == 3'd7) | s_tlast);
  assign out_free = ~m_tvalid | m_tready;
  assign len_inc  = (len == '1) ? len : len + 1'b1;
  assign user     = s_tlast ? len_inc : '0;
  assign err      = s_tlast & s_err;

  always_comb begin
    word = acc;
    word[{idx, 3'b000} +: 8] = s_tdata;
  end

  // Lanes 0..idx are live in the completing word
  always_comb begin
    strb = '0;
    for (int k = 0; k < NB; k++) begin
      strb[k] = (3'(k) <= idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc       <= '0;
      idx       <= '0;
      len       <= '0;
      pend      <= 1'b0;
      pend_data <= '0;
      pend_strb <= '0;
      pend_last <= 1'b0;
      pend_user <= '0;
      pend_err  <= 1'b0;
      m_tdata   <= '0;
      m_tstrb   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tuser   <= '0;
      m_err     <= 1'b0;
      good_pkts <= '0;
      bad_pkts  <= '0;
    end else begin
      if (accept) begin
        // Clearing on completion keeps unused lanes of short words zero
        acc <= done ? '0 : word;
        idx <= s_tlast ? 3'd0 : idx + 3'd1;
        len <= s_tlast ? '0 : len_inc;
      end

      if (m_tvalid & m_tready & m_tlast) begin
        if (m_err) bad_pkts  <= bad_pkts + 1'b1;
        else       good_pkts <= good_pkts + 1'b1;
      end

      if (pend & out_free) begin
        m_tdata  <= pend_data;
        m_tstrb  <= pend_strb;
        m_tvalid <= 1'b1;
        m_tlast  <= pend_last;
        m_tuser  <= pend_user;
        m_err    <= pend_err;
        pend     <= 1'b0;
      end else if (done & out_free) begin
        m_tdata  <= word;
        m_tstrb  <= strb;
        m_tvalid <= 1'b1;
        m_tlast  <= s_tlast;
        m_tuser  <= user;
        m_err    <= err;
      end else if (done) begin
        pend      <= 1'b1;
        pend_data <= word;
        pend_strb <= strb;
        pend_last <= s_tlast;
        pend_user <= user;
        pend_err  <= err;
      end else if (m_tvalid & m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
        m_tuser  <= '0;
        m_err    <= 1'b0;
      end
    end
  end

endmodule
